// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bundles the two handshakes of the receive buffer:
//   receiver side : rx_data, rx_full (from the UART receiver), ack (back to it)
//   CPU side      : rd_data, rd_valid, rd_strobe (first-word-fall-through pop)
//   status        : level, half_full, overflow, clear_overflow
// Modports:
//   slave  - the FIFO itself (consumes rx_*/rd_strobe, produces status/data)
//   master - the surrounding logic (receiver + CPU-side reader)
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          rx_data;
  logic                rx_full;
  logic                ack;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                rd_strobe;
  logic [DEPTH_LOG2:0] level;
  logic                half_full;
  logic                overflow;
  logic                clear_overflow;

  modport slave (
    input  rx_data,
    input  rx_full,
    output ack,
    output rd_data,
    output rd_valid,
    input  rd_strobe,
    output level,
    output half_full,
    output overflow,
    input  clear_overflow
  );

  modport master (
    output rx_data,
    output rx_full,
    input  ack,
    input  rd_data,
    input  rd_valid,
    output rd_strobe,
    input  level,
    input  half_full,
    input  overflow,
    output clear_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer behind the UART receiver. Each byte offered on
// rx_data/rx_full is acknowledged exactly once and stored in a 2^DEPTH_LOG2
// entry FIFO; the CPU side sees a first-word-fall-through read port.
// When the FIFO is full (and not popping in the same cycle) the byte is
// still acknowledged but dropped, and the sticky overflow flag is set.
// Ports:
//   clock   - single clock, same domain as the UART receiver
//   reset_n - asynchronous active-low reset
//   bus     - uart_rx_fifo_if.slave (receiver handshake, read port, status)
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_rx_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] HALF_LEVEL = LW'(DEPTH / 2);

  typedef enum logic {
    IDLE,
    WAIT_CLEAR
  } state_t;

  state_t                state_reg, state_next;
  logic                  ack_reg, ack_next;
  logic                  capture;

  logic [7:0]            mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [LW-1:0]         level_reg, level_next;
  logic                  rd_valid_reg;
  logic                  half_full_reg;
  logic                  overflow_reg, overflow_next;

  logic                  pop;
  logic                  accept;
  logic                  drop;

  // ---------------------------------------------------------------------
  // Capture FSM: one capture per rx_full assertion. WAIT_CLEAR holds off
  // until the receiver has dropped rx_full, so a slow-to-clear byte is
  // never taken twice.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.rx_full) begin
          capture    = 1'b1;
          ack_next   = 1'b1;
          state_next = WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: begin
        if (!bus.rx_full) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FIFO control. A pop in the same cycle frees the slot a full FIFO
  // needs, so full+pop still accepts the incoming byte.
  // ---------------------------------------------------------------------
  always_comb begin
    pop    = bus.rd_strobe && (level_reg != '0);
    accept = capture && ((level_reg != FULL_LEVEL) || pop);
    drop   = capture && !accept;

    level_next = level_reg;
    if (accept && !pop) begin
      level_next = level_reg + LW'(1);
    end else if (!accept && pop) begin
      level_next = level_reg - LW'(1);
    end

    // A drop in the same cycle as a clear request must leave the flag set.
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_next = 1'b0;
    end
  end

  // Storage is cleared on reset so rd_data reads 0 while empty after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= 8'h00;
      end
    end else if (accept) begin
      mem_reg[wr_ptr_reg] <= bus.rx_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      rd_valid_reg  <= 1'b0;
      half_full_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
      level_reg     <= level_next;
      // Flags are derived from the next level so they stay in step with it.
      rd_valid_reg  <= (level_next != '0);
      half_full_reg <= (level_next >= HALF_LEVEL);
      overflow_reg  <= overflow_next;
    end
  end

  assign bus.ack       = ack_reg;
  assign bus.rd_data   = mem_reg[rd_ptr_reg];
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.level     = level_reg;
  assign bus.half_full = half_full_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Bytes that should be stored are pushed
// to a scoreboard queue when offered and popped/compared when read out.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic clock = 1'b0;
  logic reset_n;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks    = 0;
  int failures  = 0;
  int ack_count = 0;
  logic [7:0] exp_q [$];

  // Counts ack pulses (value seen just before each rising edge).
  always @(posedge clock) begin
    if (bus.ack === 1'b1) ack_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Receiver model: offer a byte, wait for ack, clear rx_full on the edge
  // that samples ack, then give the FSM one cycle to return to IDLE.
  task automatic send_byte(input logic [7:0] b, input bit expect_accept);
    int n = 0;
    bus.rx_data = b;
    bus.rx_full = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (bus.ack !== 1'b1 && n < 8);
    check("ack_latency", n, 1);
    if (expect_accept) exp_q.push_back(b);
    @(negedge clock);
    check("ack_one_cycle", bus.ack, 0);
    bus.rx_full = 1'b0;
    @(negedge clock);
    $display("send %02h accept=%0d level=%0d", b, expect_accept, bus.level);
  endtask

  task automatic read_byte();
    logic [7:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check("rd_valid", bus.rd_valid, 1);
    check("rd_data", bus.rd_data, e);
    bus.rd_strobe = 1'b1;
    @(negedge clock);
    bus.rd_strobe = 1'b0;
    $display("read %02h level=%0d", e, bus.level);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int a0;
    logic [7:0] e;

    reset_n            = 1'b0;
    bus.rx_data        = 8'h00;
    bus.rx_full        = 1'b0;
    bus.rd_strobe      = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset state
    check("rst_ack",       bus.ack,       0);
    check("rst_rd_valid",  bus.rd_valid,  0);
    check("rst_level",     bus.level,     0);
    check("rst_half_full", bus.half_full, 0);
    check("rst_overflow",  bus.overflow,  0);
    check("rst_rd_data",   bus.rd_data,   8'h00);

    // Single byte
    a0 = ack_count;
    send_byte(8'hA5, 1'b1);
    check("single_ack_count", ack_count - a0, 1);
    check("single_level", bus.level, 1);
    read_byte();
    check("single_level_after", bus.level, 0);
    check("single_valid_after", bus.rd_valid, 0);

    // Fill with 00..0F, half_full tracking
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'(i), 1'b1);
      check("fill_level", bus.level, i + 1);
      check("fill_half_full", bus.half_full, (i + 1) >= DEPTH / 2);
    end
    check("fill_full_level", bus.level, DEPTH);
    for (int i = 0; i < DEPTH; i++) read_byte();
    check("drain_level", bus.level, 0);

    // 20 more bytes across the pointer wrap, with some depth in between
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h80 + 8'(i), 1'b1);
      if (i % 3 != 0) read_byte();
    end
    while (exp_q.size() != 0) read_byte();
    check("wrap_level", bus.level, 0);

    // Overflow
    for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i), 1'b1);
    a0 = ack_count;
    send_byte(8'h77, 1'b0);
    check("ovf_ack_count", ack_count - a0, 1);
    check("ovf_level", bus.level, DEPTH);
    check("ovf_flag", bus.overflow, 1);
    bus.clear_overflow = 1'b1;
    @(negedge clock);
    bus.clear_overflow = 1'b0;
    check("ovf_cleared", bus.overflow, 0);
    // Drop and clear on the same edge: set must win
    bus.clear_overflow = 1'b1;
    bus.rx_data        = 8'h77;
    bus.rx_full        = 1'b1;
    @(negedge clock);
    bus.clear_overflow = 1'b0;
    check("ovf_same_cycle_ack", bus.ack, 1);
    check("ovf_same_cycle_flag", bus.overflow, 1);
    @(negedge clock);
    bus.rx_full = 1'b0;
    @(negedge clock);
    $display("send 77 with clear_overflow overflow=%0d", bus.overflow);
    bus.clear_overflow = 1'b1;
    @(negedge clock);
    bus.clear_overflow = 1'b0;
    for (int i = 0; i < DEPTH; i++) read_byte();
    check("ovf_drain_level", bus.level, 0);

    // Full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i), 1'b1);
    e = exp_q.pop_front();
    check("fullpop_head", bus.rd_data, e);
    bus.rd_strobe = 1'b1;
    bus.rx_data   = 8'h3C;
    bus.rx_full   = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clock);
    bus.rd_strobe = 1'b0;
    check("fullpop_ack", bus.ack, 1);
    check("fullpop_level", bus.level, DEPTH);
    check("fullpop_overflow", bus.overflow, 0);
    @(negedge clock);
    bus.rx_full = 1'b0;
    @(negedge clock);
    $display("send 3C with pop level=%0d", bus.level);
    for (int i = 0; i < DEPTH; i++) read_byte();
    check("fullpop_drain_level", bus.level, 0);

    // Stuck rx_full
    a0 = ack_count;
    bus.rx_data = 8'hC3;
    bus.rx_full = 1'b1;
    exp_q.push_back(8'hC3);
    repeat (12) @(negedge clock);
    check("stuck_ack_count", ack_count - a0, 1);
    check("stuck_level", bus.level, 1);
    bus.rx_full = 1'b0;
    repeat (2) @(negedge clock);
    send_byte(8'h5A, 1'b1);
    check("stuck_second_ack", ack_count - a0, 2);
    check("stuck_second_level", bus.level, 2);
    read_byte();
    read_byte();

    // Asynchronous reset with level 5 in the middle of a capture
    for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i), 1'b1);
    check("arst_pre_level", bus.level, 5);
    bus.rx_data = 8'h12;
    bus.rx_full = 1'b1;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ack",       bus.ack,       0);
    check("arst_rd_valid",  bus.rd_valid,  0);
    check("arst_level",     bus.level,     0);
    check("arst_half_full", bus.half_full, 0);
    check("arst_overflow",  bus.overflow,  0);
    check("arst_rd_data",   bus.rd_data,   8'h00);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("arst_capture_ack",   bus.ack,      1);
    check("arst_capture_level", bus.level,    1);
    check("arst_capture_data",  bus.rd_data,  8'h12);
    check("arst_capture_valid", bus.rd_valid, 1);
    @(negedge clock);
    bus.rx_full = 1'b0;
    @(negedge clock);
    exp_q.push_back(8'h12);
    read_byte();
    check("final_level", bus.level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
